// File: rtl/mem_access_pkg.sv
// Shared constants, size encodings and state enum for the load/store initiator.
// ST_RMW_WRITE only exists when MEM_ACCESS_SUBWORD_EN is defined.
package mem_access_pkg;

  localparam int IDX_W = 16;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ACCESS    = 2'd1,
`ifdef MEM_ACCESS_SUBWORD_EN
    ST_RMW_WRITE = 2'd2,
`endif
    ST_RESP      = 2'd3
  } state_e;

endpackage

// File: rtl/mem_access_unit_if.sv
// Request/response handshake bundle between the CPU datapath and mem_access_unit.
interface mem_access_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [17:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_error;

  modport master (
    output req_valid, req_write, req_size, req_signed, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_error
  );

  modport slave (
    input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_error
  );
endinterface

// File: rtl/mem_lane_align.sv
// Little-endian lane extract/extend for loads and lane merge for subword stores.
module mem_lane_align
  import mem_access_pkg::*;
(
  input  logic [1:0]  size,
  input  logic        sgn,
  input  logic [1:0]  lane,
  input  logic [31:0] load_word,
  input  logic [31:0] old_word,
  input  logic [15:0] store_low,
  output logic [31:0] load_data,
  output logic [31:0] merge_data
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    byte_v     = load_word[{lane, 3'b000} +: 8];
    half_v     = lane[1] ? load_word[31:16] : load_word[15:0];
    load_data  = load_word;
    merge_data = old_word;
    case (size)
      SIZE_BYTE: begin
        load_data = {{24{sgn & byte_v[7]}}, byte_v};
        merge_data[{lane, 3'b000} +: 8] = store_low[7:0];
      end
      SIZE_HALF: begin
        load_data = {{16{sgn & half_v[15]}}, half_v};
        if (lane[1]) merge_data[31:16] = store_low;
        else         merge_data[15:0]  = store_low;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store initiator for the word-addressed data memory.
// Byte/halfword access with read-modify-write stores is built when MEM_ACCESS_SUBWORD_EN is defined.
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int DEPTH = 64
) (
  input  logic             clk,
  input  logic             reset,
  mem_access_unit_if.slave bus,
  output logic             mem_write,
  output logic [IDX_W-1:0] mem_addr,
  output logic [31:0]      mem_datain,
  input  logic [31:0]      mem_dataout
);

  state_e      state, state_nx;
  logic        wr_q;
  logic [17:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q;
  logic        err_q;
  logic        req_err;
  logic [31:0] load_data;

`ifdef MEM_ACCESS_SUBWORD_EN
  logic [1:0]  size_q;
  logic        sgn_q;
  logic [31:0] old_q;
  logic [31:0] merge_data;

  mem_lane_align u_align (
    .size       (size_q),
    .sgn        (sgn_q),
    .lane       (addr_q[1:0]),
    .load_word  (mem_dataout),
    .old_word   (old_q),
    .store_low  (wdata_q[15:0]),
    .load_data  (load_data),
    .merge_data (merge_data)
  );
`else
  logic unused_subword;
  assign unused_subword = ^{bus.req_signed, addr_q[1:0]};
  assign load_data      = mem_dataout;
`endif

  assign mem_addr      = addr_q[17:2];
  assign bus.req_ready = (state == ST_IDLE);
  assign bus.rsp_valid = (state == ST_RESP);
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_error = err_q;

  always_comb begin
    req_err = 1'b0;
    case (bus.req_size)
`ifdef MEM_ACCESS_SUBWORD_EN
      SIZE_BYTE: req_err = 1'b0;
      SIZE_HALF: req_err = bus.req_addr[0];
`endif
      SIZE_WORD: req_err = |bus.req_addr[1:0];
      default:   req_err = 1'b1;
    endcase
    if (32'(bus.req_addr[17:2]) >= DEPTH) req_err = 1'b1;
  end

  always_comb begin
    state_nx   = state;
    mem_write  = 1'b0;
    mem_datain = '0;
    case (state)
      ST_IDLE:
        if (bus.req_valid) state_nx = req_err ? ST_RESP : ST_ACCESS;
      ST_ACCESS: begin
        state_nx = ST_RESP;
`ifdef MEM_ACCESS_SUBWORD_EN
        if (wr_q && size_q != SIZE_WORD) state_nx = ST_RMW_WRITE;
        else
`endif
        if (wr_q) begin
          mem_write  = 1'b1;
          mem_datain = wdata_q;
        end
      end
`ifdef MEM_ACCESS_SUBWORD_EN
      ST_RMW_WRITE: begin
        mem_write  = 1'b1;
        mem_datain = merge_data;
        state_nx   = ST_RESP;
      end
`endif
      ST_RESP:
        if (bus.rsp_ready) state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
    // the write strobe is combinational, so reset must kill it within the same cycle
    if (reset) mem_write = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_IDLE;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
`ifdef MEM_ACCESS_SUBWORD_EN
      size_q  <= SIZE_WORD;
      sgn_q   <= 1'b0;
      old_q   <= '0;
`endif
    end else begin
      state <= state_nx;
      if (state == ST_IDLE && bus.req_valid) begin
        wr_q    <= bus.req_write;
        addr_q  <= bus.req_addr;
        wdata_q <= bus.req_wdata;
        rdata_q <= '0;
        err_q   <= req_err;
`ifdef MEM_ACCESS_SUBWORD_EN
        size_q  <= bus.req_size;
        sgn_q   <= bus.req_signed;
`endif
      end
      if (state == ST_ACCESS) begin
        if (!wr_q) rdata_q <= load_data;
`ifdef MEM_ACCESS_SUBWORD_EN
        old_q <= mem_dataout;
`endif
      end
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed table-driven bench for mem_access_unit with a 64-word behavioural memory.
module tb_mem_access_unit;
  import mem_access_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_init;
  logic        mem_write;
  logic [15:0] mem_addr;
  logic [31:0] mem_datain;
  logic [31:0] mem_dataout;
  logic [31:0] mem_model [64];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mem_access_unit_if bus ();

  mem_access_unit #(.DEPTH(64)) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus),
    .mem_write   (mem_write),
    .mem_addr    (mem_addr),
    .mem_datain  (mem_datain),
    .mem_dataout (mem_dataout)
  );

  assign mem_dataout = (mem_addr < 16'd64) ? mem_model[mem_addr[5:0]] : 32'hBAD0BAD0;

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 64; i++) mem_model[i] <= 32'hA500_0000 | 32'(i);
    end else if (mem_write && mem_addr < 16'd64) begin
      mem_model[mem_addr[5:0]] <= mem_datain;
    end
  end

  typedef struct {
    logic        wr;
    logic [1:0]  size;
    logic        sgn;
    logic [17:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
    logic [15:0] exp_wmask;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic wr, input logic [1:0] size, input logic sgn,
                              input logic [17:0] addr, input logic [31:0] wdata,
                              input logic [31:0] exp_rdata, input logic exp_err,
                              input int exp_lat, input logic [15:0] exp_wmask);
    vec_t v;
    v.wr = wr; v.size = size; v.sgn = sgn; v.addr = addr; v.wdata = wdata;
    v.exp_rdata = exp_rdata; v.exp_err = exp_err; v.exp_lat = exp_lat; v.exp_wmask = exp_wmask;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive_req(input vec_t v);
    bus.req_valid  = 1'b1;
    bus.req_write  = v.wr;
    bus.req_size   = v.size;
    bus.req_signed = v.sgn;
    bus.req_addr   = v.addr;
    bus.req_wdata  = v.wdata;
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int          lat;
    logic [15:0] mask;
    @(negedge clk);
    check($sformatf("v%0d_req_ready", idx), 32'(bus.req_ready), 32'd1);
    drive_req(v);
    lat  = 0;
    mask = '0;
    do begin
      @(negedge clk);
      lat++;
      if (lat == 1) bus.req_valid = 1'b0;
      mask[lat] = mem_write;
    end while (!bus.rsp_valid && lat < 12);
    check($sformatf("v%0d_latency", idx), 32'(lat), 32'(v.exp_lat));
    check($sformatf("v%0d_rdata", idx), bus.rsp_rdata, v.exp_rdata);
    check($sformatf("v%0d_error", idx), 32'(bus.rsp_error), 32'(v.exp_err));
    check($sformatf("v%0d_wmask", idx), 32'(mask), 32'(v.exp_wmask));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t v;
    int   wr_lat;

    bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_size = SIZE_WORD;
    bus.req_signed = 1'b0; bus.req_addr = '0; bus.req_wdata = '0; bus.rsp_ready = 1'b1;
    reset = 1'b1; mem_init = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0; mem_init = 1'b0;

    check("rst_req_ready", 32'(bus.req_ready), 32'd1);
    check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst_rsp_rdata", bus.rsp_rdata, 32'd0);
    check("rst_rsp_error", 32'(bus.rsp_error), 32'd0);
    check("rst_mem_write", 32'(mem_write), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_mem_datain", mem_datain, 32'd0);

    vecs.push_back(mk(1, SIZE_WORD, 0, 18'h010, 32'hDEADBEEF, 32'h0,        0, 2, 16'h0002));
    vecs.push_back(mk(0, SIZE_WORD, 0, 18'h010, 32'h0,        32'hDEADBEEF, 0, 2, 16'h0000));
    vecs.push_back(mk(0, SIZE_WORD, 0, 18'h002, 32'h0,        32'h0,        1, 1, 16'h0000));
    vecs.push_back(mk(1, SIZE_HALF, 0, 18'h005, 32'h1234,     32'h0,        1, 1, 16'h0000));
    vecs.push_back(mk(1, 2'b11,     0, 18'h008, 32'hFFFFFFFF, 32'h0,        1, 1, 16'h0000));
    vecs.push_back(mk(0, SIZE_WORD, 0, 18'h100, 32'h0,        32'h0,        1, 1, 16'h0000));
    vecs.push_back(mk(0, SIZE_WORD, 0, 18'h0FC, 32'h0,        32'hA500003F, 0, 2, 16'h0000));
    vecs.push_back(mk(1, SIZE_WORD, 0, 18'h020, 32'h11223344, 32'h0,        0, 2, 16'h0002));
    vecs.push_back(mk(0, SIZE_WORD, 0, 18'h020, 32'h0,        32'h11223344, 0, 2, 16'h0000));
`ifdef MEM_ACCESS_SUBWORD_EN
    vecs.push_back(mk(1, SIZE_BYTE, 0, 18'h021, 32'h123456AA, 32'h0,        0, 3, 16'h0004));
    vecs.push_back(mk(0, SIZE_BYTE, 1, 18'h021, 32'h0,        32'hFFFFFFAA, 0, 2, 16'h0000));
    vecs.push_back(mk(0, SIZE_BYTE, 0, 18'h021, 32'h0,        32'h000000AA, 0, 2, 16'h0000));
    vecs.push_back(mk(0, SIZE_WORD, 0, 18'h020, 32'h0,        32'h1122AA44, 0, 2, 16'h0000));
    vecs.push_back(mk(1, SIZE_HALF, 0, 18'h022, 32'hFFFFBEEF, 32'h0,        0, 3, 16'h0004));
    vecs.push_back(mk(0, SIZE_HALF, 1, 18'h022, 32'h0,        32'hFFFFBEEF, 0, 2, 16'h0000));
    vecs.push_back(mk(0, SIZE_HALF, 0, 18'h020, 32'h0,        32'h0000AA44, 0, 2, 16'h0000));
    vecs.push_back(mk(0, SIZE_BYTE, 1, 18'h023, 32'h0,        32'hFFFFFFBE, 0, 2, 16'h0000));
    vecs.push_back(mk(0, SIZE_BYTE, 1, 18'h020, 32'h0,        32'h00000044, 0, 2, 16'h0000));
    vecs.push_back(mk(0, SIZE_HALF, 0, 18'h003, 32'h0,        32'h0,        1, 1, 16'h0000));
    vecs.push_back(mk(1, SIZE_BYTE, 0, 18'h101, 32'h77,       32'h0,        1, 1, 16'h0000));
`else
    vecs.push_back(mk(0, SIZE_BYTE, 0, 18'h000, 32'h0,        32'h0,        1, 1, 16'h0000));
    vecs.push_back(mk(0, SIZE_HALF, 0, 18'h000, 32'h0,        32'h0,        1, 1, 16'h0000));
    vecs.push_back(mk(0, SIZE_WORD, 0, 18'h000, 32'h0,        32'hA5000000, 0, 2, 16'h0000));
    vecs.push_back(mk(0, SIZE_WORD, 1, 18'h020, 32'h0,        32'h11223344, 0, 2, 16'h0000));
`endif

    foreach (vecs[i]) run_vec(i, vecs[i]);

    // Backpressure: hold rsp_ready low for 5 cycles once the response is up
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    drive_req(mk(0, SIZE_WORD, 0, 18'h010, 32'h0, 32'h0, 0, 0, 16'h0));
    wr_lat = 0;
    do begin
      @(negedge clk);
      wr_lat++;
      if (wr_lat == 1) bus.req_valid = 1'b0;
    end while (!bus.rsp_valid && wr_lat < 12);
    check("bp_latency", 32'(wr_lat), 32'd2);
    for (int c = 0; c < 5; c++) begin
      check($sformatf("bp%0d_rsp_valid", c), 32'(bus.rsp_valid), 32'd1);
      check($sformatf("bp%0d_rdata", c), bus.rsp_rdata, 32'hDEADBEEF);
      check($sformatf("bp%0d_req_ready", c), 32'(bus.req_ready), 32'd0);
      check($sformatf("bp%0d_mem_write", c), 32'(mem_write), 32'd0);
      @(negedge clk);
    end
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    check("bp_done_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("bp_done_req_ready", 32'(bus.req_ready), 32'd1);

    // Reset in the write cycle of a store to word 9: the write must not land
`ifdef MEM_ACCESS_SUBWORD_EN
    v = mk(1, SIZE_BYTE, 0, 18'h024, 32'h55, 32'h0, 0, 0, 16'h0);
    wr_lat = 2;
`else
    v = mk(1, SIZE_WORD, 0, 18'h024, 32'h99999999, 32'h0, 0, 0, 16'h0);
    wr_lat = 1;
`endif
    @(negedge clk);
    drive_req(v);
    for (int c = 0; c < wr_lat; c++) begin
      @(negedge clk);
      bus.req_valid = 1'b0;
    end
    check("mr_write_before_reset", 32'(mem_write), 32'd1);
    reset = 1'b1;
    #1;
    check("mr_write_gated", 32'(mem_write), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    check("mr_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("mr_req_ready", 32'(bus.req_ready), 32'd1);
    run_vec(100, mk(0, SIZE_WORD, 0, 18'h024, 32'h0, 32'hA5000009, 0, 2, 16'h0000));
    run_vec(101, mk(0, SIZE_WORD, 0, 18'h010, 32'h0, 32'hDEADBEEF, 0, 2, 16'h0000));

    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Load/store initiator that sits between the CPU datapath and the word-addressed data memory. It accepts one load or store request at a time over a valid/ready handshake, checks alignment and range, and drives the data memory's write/addr/datain pins. It returns load data, or a store acknowledge, on a valid/ready response channel. With the subword option it also performs byte/halfword loads and read-modify-write stores.

## Interface
- DEPTH, 64: number of 32-bit words in the data memory; word index ≥ DEPTH is out of range.
- clk  in  1  clock.
- reset  in  1  reset, synchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept a request (high only in IDLE).
- req_write  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 half, 10 word, 11 illegal.
- req_signed  in  1  sign-extend subword loads.
- req_addr  in  18  byte address; word index = req_addr[17:2].
- req_wdata  in  32  store data, right-aligned for subword sizes.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer takes response.
- rsp_rdata  out  32  load result, aligned and extended; 0 for stores and errors.
- rsp_error  out  1  misaligned, out-of-range or illegal-size request.
- mem_write  out  1  data memory write strobe.
- mem_addr  out  16  data memory word address.
- mem_datain  out  32  data memory write data.
- mem_dataout  in  32  data memory read data (combinational read).

## Operation
- States: IDLE, ACCESS, RMW_WRITE, RESP.
- IDLE: req_ready=1. On req_valid: latch the request and evaluate the error check.
  - Error: go to RESP with rsp_error=1.
  - No error: go to ACCESS.
- Error check:
  - size 11 is illegal;
  - half with addr[0]=1 is misaligned;
  - word with addr[1:0]≠0 is misaligned;
  - word index ≥ DEPTH is out of range.
- Errored requests never reach memory: mem_write stays 0.
- ACCESS, load: mem_addr = latched word index. Capture mem_dataout at the clock edge, select the lane, extend, go to RESP.
- ACCESS, word store: mem_write=1, mem_datain=req_wdata, go to RESP.
- ACCESS, subword store: capture mem_dataout as the old word, go to RMW_WRITE.
- RMW_WRITE: mem_write=1. mem_datain = old word with the target lane replaced by the low byte/half of req_wdata. Go to RESP.
- Lane order is little-endian:
  - byte lane = addr[1:0], bits [8*lane+7 : 8*lane];
  - half lane = addr[1].
- Loads zero-extend unless req_signed=1, which sign-extends.
- RESP: rsp_valid=1; rsp_rdata and rsp_error are held stable until rsp_ready. On rsp_valid & rsp_ready, go to IDLE.
- mem_write is asserted in ACCESS (word store) and RMW_WRITE only, and is gated to 0 whenever reset=1.

## Timing
- Reset (synchronous):
  - state = IDLE, so req_ready=1 in the cycle after reset.
  - rsp_valid, rsp_rdata, rsp_error = 0.
  - mem_write = 0; mem_addr and mem_datain = 0.
- Let cycle N be the request accept cycle. With rsp_ready held high:
  - load or word store: rsp_valid in N+2;
  - subword store: rsp_valid in N+3;
  - error: rsp_valid in N+1.
- Word store memory update occurs at the end of N+1; subword store update at the end of N+2.
- Back-to-back: a new request can be accepted at the earliest in the cycle after the response handshake. Throughput is 1 request per 3 cycles (word) or 4 cycles (subword).
- rsp_ready low: the unit stalls in RESP indefinitely, and no memory access occurs.
- Reset mid-operation: the operation is abandoned, no write occurs in the reset cycle, and no response is produced for the abandoned request.

## Configuration
- MEM_ACCESS_SUBWORD_EN defined:
  - byte/half loads and stores are supported;
  - RMW_WRITE state is present;
  - req_signed is honoured.
- MEM_ACCESS_SUBWORD_EN undefined:
  - any req_size other than 10 returns rsp_error=1;
  - no RMW_WRITE state exists;
  - req_signed is ignored;
  - all stores complete in ACCESS.

## Structure
- Shared package mem_access_pkg holds:
  - size encodings SIZE_BYTE, SIZE_HALF, SIZE_WORD;
  - the state enum;
  - the word-index width constant (16).
- Sub-module mem_lane_align: combinational lane extract/extend for loads and lane merge for stores. It is instantiated once and compiled only under MEM_ACCESS_SUBWORD_EN.

## Test plan
- Word store then load: store 0xDEADBEEF to addr 0x10, then load addr 0x10 → rsp_rdata=0xDEADBEEF, rsp_error=0; mem_write high exactly one cycle at N+1.
- Subword RMW: word at 0x20 = 0x11223344; store byte 0xAA to 0x21 → word becomes 0x1122AA44. Signed byte load from 0x21 → 0xFFFFFFAA; unsigned → 0x000000AA.
- Errors: word load at 0x02, half store at 0x05, size 11, and word load at 0x100 (index 64) → each gives rsp_error=1 at N+1, rsp_rdata=0, mem_write never asserted.
- Backpressure: rsp_ready held low for 5 cycles → rsp_valid and rsp_rdata stable, req_ready=0; response completes once rsp_ready rises.
- Reset mid-RMW: assert reset in RMW_WRITE cycle → mem_write=0 that cycle, rsp_valid=0, req_ready=1 next cycle.
- Without MEM_ACCESS_SUBWORD_EN: byte load at 0x00 → rsp_error=1 at N+1.
